// File: rtl/alu_bist_pkg.sv
// Shared definitions for the ALU BIST sequencer: opcodes, vector record, replay table, FSM states.
package alu_bist_pkg;

  localparam int unsigned VEC_DW      = 4;
  localparam int unsigned RES_W       = 8;
  localparam int unsigned TABLE_DEPTH = 16;
  localparam int unsigned IDX_W       = 4;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_ROTL = 4'h4;
  localparam logic [3:0] OP_ROTR = 4'h5;
  localparam logic [3:0] OP_PRIO = 4'h6;
  localparam logic [3:0] OP_GRAY = 4'h7;
  localparam logic [3:0] OP_MAJ  = 4'h8;
  localparam logic [3:0] OP_PAR  = 4'h9;
  localparam logic [3:0] OP_AND  = 4'hA;
  localparam logic [3:0] OP_OR   = 4'hB;
  localparam logic [3:0] OP_SHL  = 4'hC;
  localparam logic [3:0] OP_XOR  = 4'hD;
  localparam logic [3:0] OP_GT   = 4'hE;
  localparam logic [3:0] OP_EQ   = 4'hF;

  typedef struct packed {
    logic [VEC_DW-1:0] a;
    logic [VEC_DW-1:0] b;
    logic [VEC_DW-1:0] op;
    logic [RES_W-1:0]  exp;
  } vec_t;

  // Listed from entry 15 down to entry 0 (leftmost element is the highest index).
  localparam vec_t [TABLE_DEPTH-1:0] VEC_TABLE = '{
    '{4'h7, 4'h7, OP_EQ,   8'h01},
    '{4'hC, 4'hA, OP_XOR,  8'h06},
    '{4'h5, 4'h0, OP_SHL,  8'h0A},
    '{4'hC, 4'hA, OP_OR,   8'h0E},
    '{4'hC, 4'hA, OP_AND,  8'h08},
    '{4'h6, 4'h0, OP_PAR,  8'h00},
    '{4'h5, 4'hA, OP_MAJ,  8'h00},
    '{4'h7, 4'h0, OP_GRAY, 8'h04},
    '{4'h4, 4'h0, OP_PRIO, 8'h02},
    '{4'h9, 4'h0, OP_ROTR, 8'h0C},
    '{4'h9, 4'h0, OP_ROTL, 8'h03},
    '{4'h8, 4'h0, OP_DIV,  8'hFF},
    '{4'h8, 4'h2, OP_DIV,  8'h04},
    '{4'h4, 4'h3, OP_MUL,  8'h0C},
    '{4'h7, 4'h2, OP_SUB,  8'h05},
    '{4'h3, 4'h5, OP_ADD,  8'h08}
  };

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StWait,
    StCheck,
    StDone
  } state_e;

endpackage

// File: rtl/alu_vec_rom.sv
// Combinational lookup of one BIST vector {a, b, op, exp} from the package table.
module alu_vec_rom
  import alu_bist_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output vec_t             vec
);

  always_comb begin
    vec = VEC_TABLE[idx];
  end

endmodule

// File: rtl/alu_bist_sequencer.sv
// Replays the vector table into the ALU, compares each result after LATENCY cycles and keeps a
// pass/fail summary (count and first failing index).
module alu_bist_sequencer
  import alu_bist_pkg::*;
#(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned NUM_VEC = 16,
  parameter int unsigned DW      = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [DW-1:0] alu_op,
  input  logic [7:0]    alu_result,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [4:0]    fail_count,
  output logic [3:0]    fail_index
);

  localparam int unsigned CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    a_q, a_d, b_q, b_d, op_q, op_d;
  logic [4:0]       fail_count_q, fail_count_d;
  logic [3:0]       fail_index_q, fail_index_d;
  logic             done_q, done_d, pass_q, pass_d;
  logic             mismatch;
  vec_t             vec;

  alu_vec_rom u_rom (
    .idx (idx_q),
    .vec (vec)
  );

  assign mismatch = (alu_result != vec.exp);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    fail_count_d = fail_count_q;
    fail_index_d = fail_index_q;
    done_d       = done_q;
    pass_d       = pass_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          fail_count_d = '0;
          fail_index_d = '0;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          idx_d        = '0;
          state_d      = StDrive;
        end
      end
      StDrive: begin
        a_d     = vec.a;
        b_d     = vec.b;
        op_d    = vec.op;
        cnt_d   = CW'(LATENCY);
        state_d = (LATENCY == 0) ? StCheck : StWait;
      end
      StWait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CW'(1)) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (mismatch) begin
          fail_count_d = fail_count_q + 5'd1;
          if (fail_count_q == '0) begin
            fail_index_d = idx_q;
          end
        end
        if (idx_q == LAST_IDX) begin
          // Operands drop to zero on entering DONE; pass folds in this last comparison.
          a_d     = '0;
          b_d     = '0;
          op_d    = '0;
          done_d  = 1'b1;
          pass_d  = (fail_count_q == '0) && !mismatch;
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StDrive;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      fail_count_q <= '0;
      fail_index_q <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      fail_count_q <= fail_count_d;
      fail_index_q <= fail_index_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign busy       = (state_q == StDrive) || (state_q == StWait) || (state_q == StCheck);
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_count = fail_count_q;
  assign fail_index = fail_index_q;

endmodule

// File: tb/tb_alu_bist_sequencer.sv
// Bench for alu_bist_sequencer: behavioural ALU models (golden, faulty, delayed) around two DUTs,
// one at LATENCY=1 and one at LATENCY=3.
module tb_alu_bist_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start3;
  logic [3:0] a1, b1, op1, a3, b3, op3;
  logic [7:0] res1, res3;
  logic       busy1, done1, pass1, busy3, done3, pass3;
  logic [4:0] fc1, fc3;
  logic [3:0] fi1, fi3;

  int fault_mode;
  bit slow3;
  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] s1, s2, s3, s4;

  always #5 clk = ~clk;

  alu_bist_sequencer #(.LATENCY(1), .NUM_VEC(16), .DW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start1),
    .alu_a      (a1),
    .alu_b      (b1),
    .alu_op     (op1),
    .alu_result (res1),
    .busy       (busy1),
    .done       (done1),
    .pass       (pass1),
    .fail_count (fc1),
    .fail_index (fi1)
  );

  alu_bist_sequencer #(.LATENCY(3), .NUM_VEC(16), .DW(4)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .start      (start3),
    .alu_a      (a3),
    .alu_b      (b3),
    .alu_op     (op3),
    .alu_result (res3),
    .busy       (busy3),
    .done       (done3),
    .pass       (pass3),
    .fail_count (fc3),
    .fail_index (fi3)
  );

  // mode 1: ADD off by one; mode 2: OR and XOR corrupted.
  function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] op, input int mode);
    logic [7:0] r;
    r = 8'h00;
    case (op)
      4'h0: r = {4'h0, a} + {4'h0, b} + ((mode == 1) ? 8'h01 : 8'h00);
      4'h1: r = {4'h0, a} - {4'h0, b};
      4'h2: r = {4'h0, a} * {4'h0, b};
      4'h3: r = (b == 4'h0) ? 8'hFF : {4'h0, a} / {4'h0, b};
      4'h4: r = {4'h0, a[2:0], a[3]};
      4'h5: r = {4'h0, a[0], a[3:1]};
      4'h6: for (int i = 0; i < 4; i++) if (a[i]) r = 8'(i);
      4'h7: r = {4'h0, a ^ (a >> 1)};
      4'h8: r = {4'h0, a & b};
      4'h9: r = {7'h00, ^a};
      4'hA: r = {4'h0, a & b};
      4'hB: r = {4'h0, a | b} ^ ((mode == 2) ? 8'h01 : 8'h00);
      4'hC: r = {3'h0, a, 1'b0};
      4'hD: r = {4'h0, a ^ b} ^ ((mode == 2) ? 8'h01 : 8'h00);
      4'hE: r = {7'h00, a > b};
      default: r = {7'h00, a == b};
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    res1 <= alu_model(a1, b1, op1, fault_mode);
    s1   <= alu_model(a3, b3, op3, 0);
    s2   <= s1;
    s3   <= s2;
    s4   <= s3;
  end

  assign res3 = slow3 ? s4 : s3;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Pulses start (that edge is cycle 0) and returns the cycle on which done is first seen.
  task automatic run_bist(input bit use3, input int repulse_at, output int cycles);
    @(negedge clk);
    if (use3) start3 = 1'b1;
    else start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start3 = 1'b0;
    cycles = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      start1 = 1'b0;
      if (n == 1) check_eq("busy_after_start", use3 ? busy3 : busy1, 1);
      if (n == repulse_at - 1) start1 = 1'b1;
      if ((use3 ? done3 : done1) === 1'b1) begin
        cycles = n;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    rst        = 1'b1;
    start1     = 1'b0;
    start3     = 1'b0;
    fault_mode = 0;
    slow3      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_done", done1, 0);
    check_eq("rst_pass", pass1, 0);
    check_eq("rst_fail_count", fc1, 0);
    check_eq("rst_busy", busy1, 0);
    check_eq("rst_alu_ops", {a1, b1, op1}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Golden model
    run_bist(1'b0, 0, cyc);
    check_eq("s1_done_cycle", cyc, 48);
    check_eq("s1_pass", pass1, 1);
    check_eq("s1_fail_count", fc1, 0);
    check_eq("s1_fail_index", fi1, 0);
    check_eq("s1_busy_at_done", busy1, 0);
    check_eq("s1_alu_ops_idle", {a1, b1, op1}, 0);

    // ADD off by one: only vector 0 uses ADD
    fault_mode = 1;
    run_bist(1'b0, 0, cyc);
    check_eq("s2_done_cycle", cyc, 48);
    check_eq("s2_pass", pass1, 0);
    check_eq("s2_fail_count", fc1, 1);
    check_eq("s2_fail_index", fi1, 0);

    // OR (vector 12) and XOR (vector 14) corrupted
    fault_mode = 2;
    run_bist(1'b0, 0, cyc);
    check_eq("s3_pass", pass1, 0);
    check_eq("s3_fail_count", fc1, 2);
    check_eq("s3_fail_index", fi1, 12);

    // Golden again with a start re-pulse at cycle 10 while busy
    fault_mode = 0;
    run_bist(1'b0, 10, cyc);
    check_eq("s4_done_cycle", cyc, 48);
    check_eq("s4_pass", pass1, 1);
    check_eq("s4_fail_count", fc1, 0);
    check_eq("s4_fail_index", fi1, 0);

    // Reset in the middle of vector 7 (A=4, op=6)
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (23) @(posedge clk);
    #1;
    check_eq("s5_vec7_a", a1, 4'h4);
    check_eq("s5_vec7_op", op1, 4'h6);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("s5_rst_busy", busy1, 0);
    check_eq("s5_rst_done", done1, 0);
    check_eq("s5_rst_alu_ops", {a1, b1, op1}, 0);
    check_eq("s5_rst_summary", {pass1, fc1, fi1}, 0);
    @(negedge clk);
    rst = 1'b0;
    run_bist(1'b0, 0, cyc);
    check_eq("s5_done_cycle", cyc, 48);
    check_eq("s5_pass", pass1, 1);
    check_eq("s5_fail_count", fc1, 0);

    // LATENCY=3: model delayed by 3 matches; a model one cycle slower must be caught
    run_bist(1'b1, 0, cyc);
    check_eq("s6_done_cycle", cyc, 80);
    check_eq("s6_pass", pass3, 1);
    check_eq("s6_fail_count", fc3, 0);
    slow3 = 1'b1;
    run_bist(1'b1, 0, cyc);
    check_eq("s6_slow_done_cycle", cyc, 80);
    check_eq("s6_slow_pass", pass3, 0);
    check_eq("s6_slow_fail_index", fi3, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
